uart_tx: RTL and testbench

UART serial transmitter, the transmit half of the team's UART link. It serialises one parallel byte per frame onto a single line: start bit, DBIT data bits LSB first, optional parity, then stop bit(s). Bit timing comes from the shared 16x oversampling baud tick (s_tick), so each bit lasts 16 ticks. A one-entry holding register lets the host queue the next byte while the current frame is shifting out.

---
 rtl/uart_tx.sv | 161 ++++++++++++++++
 tb/tb_uart_tx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start, DBIT data bits LSB first, optional parity, stop bit(s),
// timed from a 16x oversampling tick, with a one-entry holding register.
module uart_tx #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       tx_start,
    input  logic [7:0] din,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [2:0] LAST_BIT = 3'(DBIT - 1);
    localparam logic [5:0] STOP_END = 6'(SB_TICK - 1);

    state_t     state_q, state_d;
    logic [5:0] tick_q, tick_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_vld_q, hold_vld_d;
    logic       hold_par_q, hold_par_d;
    logic       par_q, par_d;
    logic       tx_q, tx_d;
    logic       done_q, done_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            hold_par_q <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            hold_par_q <= hold_par_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        hold_par_d = hold_par_q;
        par_d      = par_q;
        tx_d       = tx_q;
        done_d     = 1'b0;

        // Accept and the IDLE hand-off never coincide: one needs the hold empty, the other full.
        if (tx_start && !hold_vld_q) begin
            hold_d     = din;
            hold_par_d = (^din[DBIT-1:0]) ^ (PARITY_ODD != 0);
            hold_vld_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (hold_vld_q) begin
                    state_d    = START;
                    tx_d       = 1'b0;
                    shift_d    = hold_q;
                    par_d      = hold_par_q;
                    hold_vld_d = 1'b0;
                    tick_d     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (tick_q == 6'd15) begin
                        state_d = DATA;
                        tx_d    = shift_q[0];
                        bit_d   = '0;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + 6'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tick_q == 6'd15) begin
                        tick_d  = '0;
                        shift_d = shift_q >> 1;
                        if (bit_q == LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                state_d = PARITY;
                                tx_d    = par_q;
                            end else begin
                                state_d = STOP;
                                tx_d    = 1'b1;
                            end
                        end else begin
                            bit_d = bit_q + 3'd1;
                            tx_d  = shift_q[1];
                        end
                    end else begin
                        tick_d = tick_q + 6'd1;
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (tick_q == 6'd15) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + 6'd1;
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (s_tick) begin
                    if (tick_q == STOP_END) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        tick_d  = '0;
                    end else begin
                        tick_d = tick_q + 6'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx_ready = ~hold_vld_q;
    assign tx_busy  = (state_q != IDLE);
    assign tx_done  = done_q;
    assign tx       = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations (8N1, 8E1, 8O1, 5N2) share clock, tick and reset;
// a scoreboard of expected frames is checked bit by bit by one monitor per instance.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_tick;
    logic [3:0] start_v;
    logic [7:0] din;
    logic [3:0] rdy_w, busy_w, done_w, tx_w;
    int         ncmp = 0;
    int         nerr = 0;
    int         cyc  = 0;

    typedef struct {
        int          k;
        logic [11:0] bits;   // bit 0 = start level, last slot = stop level
        int          nb;
        int          total;  // frame length in s_ticks
        int          gap;    // clks from previous tx_done cycle to START, -1 = don't care
        bit          abort;
    } exp_t;
    exp_t sbq[$];

    always #5 clk = ~clk;

    uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(0), .PARITY_ODD(0)) u0 (
        .clk(clk), .reset(rst_n), .s_tick(s_tick), .tx_start(start_v[0]), .din(din),
        .tx_ready(rdy_w[0]), .tx_busy(busy_w[0]), .tx_done(done_w[0]), .tx(tx_w[0]));
    uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
        .clk(clk), .reset(rst_n), .s_tick(s_tick), .tx_start(start_v[1]), .din(din),
        .tx_ready(rdy_w[1]), .tx_busy(busy_w[1]), .tx_done(done_w[1]), .tx(tx_w[1]));
    uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
        .clk(clk), .reset(rst_n), .s_tick(s_tick), .tx_start(start_v[2]), .din(din),
        .tx_ready(rdy_w[2]), .tx_busy(busy_w[2]), .tx_done(done_w[2]), .tx(tx_w[2]));
    uart_tx #(.DBIT(5), .SB_TICK(32), .PARITY_EN(0), .PARITY_ODD(0)) u3 (
        .clk(clk), .reset(rst_n), .s_tick(s_tick), .tx_start(start_v[3]), .din(din),
        .tx_ready(rdy_w[3]), .tx_busy(busy_w[3]), .tx_done(done_w[3]), .tx(tx_w[3]));

    // s_tick changes on the falling edge, so it is stable around every rising edge
    initial begin
        s_tick = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            s_tick = (cyc % 4 == 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon(input int k);
        exp_t e;
        int   ticks, gap, bi, n;
        bit   ok, ab, post;
        gap  = 1000;
        post = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst_n !== 1'b1) begin
                gap  = 1000;
                post = 1'b0;
                continue;
            end
            gap++;
            if (post) begin
                chk($sformatf("dut%0d_done_width", k), done_w[k], 1'b0);
                post = 1'b0;
            end else if (done_w[k] === 1'b1) begin
                ncmp++; nerr++;
                $display("FAIL dut%0d_stray_done: got 1 expected 0", k);
            end
            if (tx_w[k] !== 1'b0) continue;
            if (sbq.size() == 0) begin
                ncmp++; nerr++;
                $display("FAIL dut%0d_unexpected_frame: got start bit expected idle line", k);
                n = 0;
                while (tx_w[k] !== 1'b1 && n < 2000) begin @(posedge clk); #1; n++; end
                continue;
            end
            e = sbq.pop_front();
            chk($sformatf("dut%0d_frame_owner", k), k, e.k);
            if (e.gap >= 0) chk($sformatf("dut%0d_gap", k), gap, e.gap);
            ok    = 1'b1;
            ab    = 1'b0;
            ticks = 0;
            while (ticks < e.total) begin
                @(posedge clk); #1;
                if (rst_n !== 1'b1) begin ab = 1'b1; break; end
                if (s_tick) ticks++;
                bi = ticks / 16;
                if (bi > e.nb - 1) bi = e.nb - 1;
                if (tx_w[k] !== e.bits[bi]) ok = 1'b0;
                if (ticks < e.total && (busy_w[k] !== 1'b1 || done_w[k] !== 1'b0)) ok = 1'b0;
                if (s_tick && ticks % 16 == 8)
                    chk($sformatf("dut%0d_bit%0d", k, bi), tx_w[k], e.bits[bi]);
            end
            chk($sformatf("dut%0d_frame_stable", k), ok, 1'b1);
            chk($sformatf("dut%0d_aborted", k), ab, e.abort);
            if (!ab) begin
                chk($sformatf("dut%0d_done_pulse", k), done_w[k], 1'b1);
                chk($sformatf("dut%0d_busy_at_done", k), busy_w[k], 1'b0);
                post = 1'b1;
                gap  = 0;
            end else begin
                gap = 1000;
            end
        end
    endtask

    task automatic send(input int k, input logic [7:0] d, input logic [11:0] bits,
                        input int nb, input int total, input int gap, input bit ab);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (rdy_w[k] !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) begin
            ncmp++; nerr++;
            $display("FAIL dut%0d_send_timeout: got tx_ready=0 expected 1", k);
        end
        e.k = k; e.bits = bits; e.nb = nb; e.total = total; e.gap = gap; e.abort = ab;
        sbq.push_back(e);
        din        = d;
        start_v[k] = 1'b1;
        @(posedge clk); #1;
        chk($sformatf("dut%0d_rdy_after_accept", k), rdy_w[k], 1'b0);
        @(negedge clk);
        start_v[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while (n < 3000 && !(sbq.size() == 0 && busy_w[k] === 1'b0 && rdy_w[k] === 1'b1 &&
                             done_w[k] === 1'b0)) begin
            @(negedge clk); n++;
        end
        if (n >= 3000) begin
            ncmp++; nerr++;
            $display("FAIL dut%0d_idle_timeout: got busy=%0b expected 0", k, busy_w[k]);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_ticks(input int t);
        int c = 0;
        while (c < t) begin
            @(posedge clk); #1;
            if (s_tick) c++;
        end
    endtask

    task automatic wait_done(input int k);
        int n = 0;
        @(posedge clk); #1;
        while (done_w[k] !== 1'b1 && n < 3000) begin @(posedge clk); #1; n++; end
        if (n >= 3000) begin
            ncmp++; nerr++;
            $display("FAIL dut%0d_done_timeout: got tx_done=0 expected 1", k);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            mon(0);
            mon(1);
            mon(2);
            mon(3);
        join_none
    end

    initial begin
        int bad;
        rst_n   = 1'b0;
        start_v = '0;
        din     = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("dut%0d_rst_tx", k), tx_w[k], 1'b1);
            chk($sformatf("dut%0d_rst_ready", k), rdy_w[k], 1'b1);
            chk($sformatf("dut%0d_rst_busy", k), busy_w[k], 1'b0);
            chk($sformatf("dut%0d_rst_done", k), done_w[k], 1'b0);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // 8N1 frame of A5
        send(0, 8'hA5, 12'h34A, 10, 160, -1, 1'b0);
        wait_idle(0);

        // even and odd parity on 07
        send(1, 8'h07, 12'h60E, 11, 176, -1, 1'b0);
        wait_idle(1);
        send(2, 8'h07, 12'h40E, 11, 176, -1, 1'b0);
        wait_idle(2);

        // back-to-back 55 then AA
        send(0, 8'h55, 12'h2AA, 10, 160, -1, 1'b0);
        @(posedge clk); #1;
        chk("rdy_freed_after_start", rdy_w[0], 1'b1);
        wait_ticks(40);
        send(0, 8'hAA, 12'h354, 10, 160, 1, 1'b0);
        wait_done(0);
        chk("rdy_held_at_done", rdy_w[0], 1'b0);
        @(posedge clk); #1;
        chk("rdy_freed_at_next_start", rdy_w[0], 1'b1);
        wait_idle(0);

        // write while the holding register is full is ignored
        send(0, 8'h12, 12'h224, 10, 160, -1, 1'b0);
        send(0, 8'h96, 12'h32C, 10, 160, 1, 1'b0);
        din        = 8'hFF;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        chk("rdy_after_ignored_write", rdy_w[0], 1'b0);
        wait_idle(0);

        // reset during data bit 3 of 3C with 77 queued
        send(0, 8'h3C, 12'h278, 10, 160, -1, 1'b1);
        @(negedge clk);
        din        = 8'h77;
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        chk("queued_before_reset", rdy_w[0], 1'b0);
        wait_ticks(68);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_tx", tx_w[0], 1'b1);
        chk("midreset_ready", rdy_w[0], 1'b1);
        chk("midreset_busy", busy_w[0], 1'b0);
        chk("midreset_done", done_w[0], 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (300) begin
            @(posedge clk); #1;
            if (tx_w[0] !== 1'b1 || done_w[0] !== 1'b0) bad++;
        end
        chk("queued_byte_discarded", bad, 0);
        send(0, 8'hC3, 12'h386, 10, 160, -1, 1'b0);
        wait_idle(0);

        // 5 data bits, 2 stop bits; din[7:5] must not matter
        send(3, 8'hE3, 12'h046, 7, 128, -1, 1'b0);
        send(3, 8'h03, 12'h046, 7, 128, 1, 1'b0);
        wait_idle(3);

        repeat (10) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
